// File: rtl/xc_malu_divrem_seq_if.sv
// Request/response handshake between the MALU issue logic and the divide sequencer.
interface xc_malu_divrem_seq_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic        req_signed;
  logic        req_rem;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;

  // Issue side: presents requests, consumes responses.
  modport master (
    output req_valid, req_rs1, req_rs2, req_signed, req_rem, rsp_ready,
    input  req_ready, rsp_valid, rsp_result
  );

  // Sequencer side: accepts requests, produces responses.
  modport slave (
    input  req_valid, req_rs1, req_rs2, req_signed, req_rem, rsp_ready,
    output req_ready, rsp_valid, rsp_result
  );

endinterface

// File: rtl/xc_malu_divrem_seq.sv
// Sequencer for the radix-2 restoring divide step datapath: owns the iteration
// state, applies signed correction and divide-by-zero results, and talks
// valid/ready to the issue logic.
module xc_malu_divrem_seq #(
  parameter bit DIV0_BYPASS = 1'b1
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       flush,
  xc_malu_divrem_seq_if.slave        bus,
  output logic                       busy,
  output logic                       dp_valid,
  output logic                       dp_op_signed,
  output logic                       dp_flush,
  output logic [31:0]                dp_rs1,
  output logic [31:0]                dp_rs2,
  output logic [5:0]                 dp_counter,
  output logic [63:0]                dp_accumulator,
  output logic [31:0]                dp_arg0,
  output logic [31:0]                dp_arg1,
  input  logic [63:0]                dp_n_accumulator,
  input  logic [31:0]                dp_n_arg0,
  input  logic [31:0]                dp_n_arg1,
  input  logic                       dp_finished
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned ACC_W  = 64;
  localparam int unsigned LAST_I = 31;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_FIX,
    S_RESP
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  counter_q;
  logic [ACC_W-1:0]  acc_q;
  logic [XLEN-1:0]   arg0_q;
  logic [XLEN-1:0]   arg1_q;
  logic [XLEN-1:0]   rs1_q;
  logic [XLEN-1:0]   rs2_q;
  logic              signed_q;
  logic              rem_q;
  logic              neg_q_q;
  logic              neg_r_q;
  logic              div_zero_q;
  logic [XLEN-1:0]   rsp_result_q;
  logic              rsp_valid_q;
  logic              req_ready_q;
  logic              busy_q;
  logic              dp_valid_q;
  logic [XLEN-1:0]   fix_result;
  logic              req_zero;

  assign req_zero = (bus.req_rs2 == XLEN'(0));

  // Final result selection applied in the FIX cycle.
  always_comb begin
    fix_result = '0;
    if (div_zero_q) begin
      fix_result = rem_q ? rs1_q : {XLEN{1'b1}};
    end else if (rem_q) begin
      fix_result = neg_r_q ? (XLEN'(0) - arg0_q) : arg0_q;
    end else begin
      fix_result = neg_q_q ? (XLEN'(0) - arg1_q) : arg1_q;
    end
  end

  // Sequencer FSM with registered outputs and iteration state.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      counter_q    <= '0;
      acc_q        <= '0;
      arg0_q       <= '0;
      arg1_q       <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      signed_q     <= 1'b0;
      rem_q        <= 1'b0;
      neg_q_q      <= 1'b0;
      neg_r_q      <= 1'b0;
      div_zero_q   <= 1'b0;
      rsp_result_q <= '0;
      rsp_valid_q  <= 1'b0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      dp_valid_q   <= 1'b0;
    end else if (flush) begin
      state_q      <= S_IDLE;
      rsp_valid_q  <= 1'b0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      dp_valid_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            rs1_q       <= bus.req_rs1;
            rs2_q       <= bus.req_rs2;
            signed_q    <= bus.req_signed;
            rem_q       <= bus.req_rem;
            neg_q_q     <= bus.req_signed && (bus.req_rs1[XLEN-1] ^ bus.req_rs2[XLEN-1]);
            neg_r_q     <= bus.req_signed && bus.req_rs1[XLEN-1];
            div_zero_q  <= req_zero;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (DIV0_BYPASS && req_zero) begin
              state_q    <= S_FIX;
              dp_valid_q <= 1'b0;
            end else begin
              state_q    <= S_START;
              dp_valid_q <= 1'b1;
            end
          end
        end
        S_START: begin
          acc_q     <= dp_n_accumulator;
          arg0_q    <= dp_n_arg0;
          arg1_q    <= dp_n_arg1;
          counter_q <= '0;
          state_q   <= S_RUN;
        end
        S_RUN: begin
          acc_q     <= dp_n_accumulator;
          arg0_q    <= dp_n_arg0;
          arg1_q    <= dp_n_arg1;
          counter_q <= counter_q + CNT_W'(1);
          if (counter_q == CNT_W'(LAST_I)) begin
            state_q    <= S_FIX;
            dp_valid_q <= 1'b0;
          end
        end
        S_FIX: begin
          rsp_result_q <= fix_result;
          rsp_valid_q  <= 1'b1;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          dp_valid_q  <= 1'b0;
        end
      endcase
    end
  end

  // The datapath must report completion once the last step has committed.
  always_ff @(posedge clock) begin
    if (resetn && (state_q == S_FIX) && !(DIV0_BYPASS && div_zero_q)) begin
      assert (dp_finished);
    end
  end

  assign bus.req_ready   = req_ready_q && !flush;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_result  = rsp_result_q;
  assign busy            = busy_q;
  assign dp_valid        = dp_valid_q;
  assign dp_op_signed    = signed_q;
  assign dp_flush        = flush || !resetn || (state_q == S_FIX);
  assign dp_rs1          = rs1_q;
  assign dp_rs2          = rs2_q;
  assign dp_counter      = counter_q;
  assign dp_accumulator  = acc_q;
  assign dp_arg0         = arg0_q;
  assign dp_arg1         = arg1_q;

endmodule

// File: tb/tb_xc_malu_divrem_seq.sv
// Bench for the divide sequencer: two instances (zero-divisor bypass on/off),
// each driven by a behavioural restoring-divide datapath, checked against
// plain-arithmetic RISC-V divide/remainder results.
module tb_xc_malu_divrem_seq;

  logic clock = 1'b0;
  logic resetn;
  logic flush;
  always #5 clock = ~clock;

  // Shared stimulus; sel picks which instance sees the request (0 = bypass, 1 = iterate).
  logic        sel;
  logic        req_valid;
  logic [31:0] req_rs1, req_rs2;
  logic        req_signed, req_rem, rsp_ready;

  xc_malu_divrem_seq_if bus0 ();
  xc_malu_divrem_seq_if bus1 ();

  assign bus0.req_valid  = req_valid && !sel;
  assign bus1.req_valid  = req_valid && sel;
  assign bus0.req_rs1    = req_rs1;
  assign bus1.req_rs1    = req_rs1;
  assign bus0.req_rs2    = req_rs2;
  assign bus1.req_rs2    = req_rs2;
  assign bus0.req_signed = req_signed;
  assign bus1.req_signed = req_signed;
  assign bus0.req_rem    = req_rem;
  assign bus1.req_rem    = req_rem;
  assign bus0.rsp_ready  = rsp_ready || sel;
  assign bus1.rsp_ready  = rsp_ready || !sel;

  logic        busy0, dp_valid0, dp_sg0, dp_flush0, dp_fin0, run0 = 1'b0;
  logic        busy1, dp_valid1, dp_sg1, dp_flush1, dp_fin1, run1 = 1'b0;
  logic [31:0] dp_rs1_0, dp_rs2_0, dp_a0_0, dp_a1_0, n_a0_0, n_a1_0;
  logic [31:0] dp_rs1_1, dp_rs2_1, dp_a0_1, dp_a1_1, n_a0_1, n_a1_1;
  logic [5:0]  dp_cnt0, dp_cnt1;
  logic [63:0] dp_acc0, dp_acc1, n_acc0, n_acc1;

  xc_malu_divrem_seq #(.DIV0_BYPASS(1'b1)) u_dut_byp (
    .clock(clock), .resetn(resetn), .flush(flush), .bus(bus0),
    .busy(busy0), .dp_valid(dp_valid0), .dp_op_signed(dp_sg0), .dp_flush(dp_flush0),
    .dp_rs1(dp_rs1_0), .dp_rs2(dp_rs2_0), .dp_counter(dp_cnt0), .dp_accumulator(dp_acc0),
    .dp_arg0(dp_a0_0), .dp_arg1(dp_a1_0), .dp_n_accumulator(n_acc0),
    .dp_n_arg0(n_a0_0), .dp_n_arg1(n_a1_0), .dp_finished(dp_fin0)
  );

  xc_malu_divrem_seq #(.DIV0_BYPASS(1'b0)) u_dut_itr (
    .clock(clock), .resetn(resetn), .flush(flush), .bus(bus1),
    .busy(busy1), .dp_valid(dp_valid1), .dp_op_signed(dp_sg1), .dp_flush(dp_flush1),
    .dp_rs1(dp_rs1_1), .dp_rs2(dp_rs2_1), .dp_counter(dp_cnt1), .dp_accumulator(dp_acc1),
    .dp_arg0(dp_a0_1), .dp_arg1(dp_a1_1), .dp_n_accumulator(n_acc1),
    .dp_n_arg0(n_a0_1), .dp_n_arg1(n_a1_1), .dp_finished(dp_fin1)
  );

  // Behavioural divide step: first valid cycle loads |divisor|<<31 and |dividend|,
  // later cycles do one restoring subtract-and-shift.
  function automatic logic [127:0] dp_model(input logic run, input logic sg,
                                            input logic [31:0] rs1, input logic [31:0] rs2,
                                            input logic [63:0] acc, input logic [31:0] a0,
                                            input logic [31:0] a1);
    logic [31:0] m1, m2;
    m1 = (sg && rs1[31]) ? (32'd0 - rs1) : rs1;
    m2 = (sg && rs2[31]) ? (32'd0 - rs2) : rs2;
    if (!run) return {1'b0, m2, 31'd0, m1, 32'd0};
    if (acc <= {32'd0, a0}) return {acc >> 1, a0 - acc[31:0], a1[30:0], 1'b1};
    return {acc >> 1, a0, a1[30:0], 1'b0};
  endfunction

  assign {n_acc0, n_a0_0, n_a1_0} = dp_model(run0, dp_sg0, dp_rs1_0, dp_rs2_0, dp_acc0, dp_a0_0, dp_a1_0);
  assign {n_acc1, n_a0_1, n_a1_1} = dp_model(run1, dp_sg1, dp_rs1_1, dp_rs2_1, dp_acc1, dp_a0_1, dp_a1_1);
  assign dp_fin0 = run0 && (dp_cnt0 == 6'd32);
  assign dp_fin1 = run1 && (dp_cnt1 == 6'd32);

  // Datapath run flag: set by the first valid cycle, cleared by flush.
  always @(posedge clock) begin
    run0 <= dp_flush0 ? 1'b0 : (dp_valid0 ? 1'b1 : run0);
    run1 <= dp_flush1 ? 1'b0 : (dp_valid1 ? 1'b1 : run1);
  end

  logic        req_ready_m, rsp_valid_m, busy_m, dp_valid_m, dp_flush_m, run_m;
  logic [31:0] rsp_result_m, dp_a0_m, dp_a1_m;
  logic [5:0]  dp_cnt_m;
  logic [63:0] dp_acc_m;
  assign req_ready_m  = sel ? bus1.req_ready  : bus0.req_ready;
  assign rsp_valid_m  = sel ? bus1.rsp_valid  : bus0.rsp_valid;
  assign rsp_result_m = sel ? bus1.rsp_result : bus0.rsp_result;
  assign busy_m       = sel ? busy1     : busy0;
  assign dp_valid_m   = sel ? dp_valid1 : dp_valid0;
  assign dp_flush_m   = sel ? dp_flush1 : dp_flush0;
  assign run_m        = sel ? run1      : run0;
  assign dp_cnt_m     = sel ? dp_cnt1   : dp_cnt0;
  assign dp_acc_m     = sel ? dp_acc1   : dp_acc0;
  assign dp_a0_m      = sel ? dp_a0_1   : dp_a0_0;
  assign dp_a1_m      = sel ? dp_a1_1   : dp_a1_0;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // RISC-V DIV/DIVU/REM/REMU result.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic sg, input logic rm);
    int sa, sb;
    if (b == 32'd0) return rm ? a : 32'hFFFF_FFFF;
    if (!sg) return rm ? (a % b) : (a / b);
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rm ? 32'd0 : 32'h8000_0000;
    sa = $signed(a);
    sb = $signed(b);
    return rm ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  task automatic send(input logic s, input logic [31:0] a, input logic [31:0] b,
                      input logic sg, input logic rm);
    int n = 0;
    sel = s;
    #1;
    while (!req_ready_m && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    chk("send req_ready", {63'd0, req_ready_m}, 64'd1);
    req_rs1 = a; req_rs2 = b; req_signed = sg; req_rem = rm; req_valid = 1'b1;
  endtask

  // Edges from request presentation to rsp_valid, plus datapath RUN cycles seen.
  task automatic wait_rsp(output logic [31:0] res, output int lat, output int runs);
    lat = 0;
    runs = 0;
    while (lat < 200) begin
      @(posedge clock); #1;
      lat++;
      if (lat == 1) req_valid = 1'b0;
      if (dp_valid_m && run_m) runs++;
      if (rsp_valid_m) break;
    end
    chk("rsp_valid seen", {63'd0, rsp_valid_m}, 64'd1);
    res = rsp_result_m;
  endtask

  task automatic ack();
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic        sel;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        sg;
    logic        rm;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t        vecs[14];
  logic [31:0] res, r0, a, b;
  int          lat, runs, n;
  logic        s, sg, rm;

  initial begin
    vecs[0]  = '{1'b0, 32'd100,        32'd7,          1'b0, 1'b0, 32'd14,         35};
    vecs[1]  = '{1'b0, 32'd100,        32'd7,          1'b0, 1'b1, 32'd2,          35};
    vecs[2]  = '{1'b0, 32'hFFFF_FF9C,  32'd7,          1'b1, 1'b0, 32'hFFFF_FFF2,  35};
    vecs[3]  = '{1'b0, 32'hFFFF_FF9C,  32'd7,          1'b1, 1'b1, 32'hFFFF_FFFE,  35};
    vecs[4]  = '{1'b0, 32'd100,        32'hFFFF_FFF9,  1'b1, 1'b0, 32'hFFFF_FFF2,  35};
    vecs[5]  = '{1'b0, 32'd100,        32'hFFFF_FFF9,  1'b1, 1'b1, 32'd2,          35};
    vecs[6]  = '{1'b0, 32'h8000_0005,  32'd0,          1'b1, 1'b0, 32'hFFFF_FFFF,  2};
    vecs[7]  = '{1'b0, 32'h8000_0005,  32'd0,          1'b1, 1'b1, 32'h8000_0005,  2};
    vecs[8]  = '{1'b1, 32'h8000_0005,  32'd0,          1'b1, 1'b0, 32'hFFFF_FFFF,  35};
    vecs[9]  = '{1'b1, 32'h8000_0005,  32'd0,          1'b1, 1'b1, 32'h8000_0005,  35};
    vecs[10] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 1'b0, 32'h8000_0000,  35};
    vecs[11] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 1'b1, 32'd0,          35};
    vecs[12] = '{1'b1, 32'hFFFF_FFFF,  32'd1,          1'b0, 1'b0, 32'hFFFF_FFFF,  35};
    vecs[13] = '{1'b1, 32'd5,          32'hFFFF_FFFF,  1'b0, 1'b1, 32'd5,          35};

    resetn = 1'b0; flush = 1'b0; sel = 1'b0; req_valid = 1'b0;
    req_rs1 = '0; req_rs2 = '0; req_signed = 1'b0; req_rem = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset req_ready",  {63'd0, req_ready_m}, 64'd1);
    chk("reset rsp_valid",  {63'd0, rsp_valid_m}, 64'd0);
    chk("reset busy",       {63'd0, busy_m}, 64'd0);
    chk("reset dp_valid",   {63'd0, dp_valid_m}, 64'd0);
    chk("reset dp_flush",   {63'd0, dp_flush_m}, 64'd1);
    chk("reset counter",    {58'd0, dp_cnt_m}, 64'd0);
    chk("reset acc",        dp_acc_m, 64'd0);
    chk("reset rsp_result", {32'd0, rsp_result_m}, 64'd0);
    resetn = 1'b1;
    @(posedge clock); #1;
    chk("post-reset dp_flush", {63'd0, dp_flush_m}, 64'd0);

    // Directed vectors.
    for (int i = 0; i < 14; i++) begin
      send(vecs[i].sel, vecs[i].rs1, vecs[i].rs2, vecs[i].sg, vecs[i].rm);
      wait_rsp(res, lat, runs);
      ack();
      chk($sformatf("vec%0d result", i), {32'd0, res}, {32'd0, vecs[i].exp});
      chk($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("vec%0d run cycles", i), 64'(runs), (vecs[i].lat == 35) ? 64'd32 : 64'd0);
      chk($sformatf("vec%0d rsp_valid drop", i), {63'd0, rsp_valid_m}, 64'd0);
    end

    // Flush in the middle of RUN.
    send(1'b0, 32'd1000, 32'd3, 1'b0, 1'b0);
    n = 0;
    while (n < 60) begin
      @(posedge clock); #1;
      n++;
      req_valid = 1'b0;
      if (dp_valid_m && run_m && dp_cnt_m == 6'd10) break;
    end
    chk("flush counter reached", {58'd0, dp_cnt_m}, 64'd10);
    flush = 1'b1;
    #1;
    chk("flush dp_flush", {63'd0, dp_flush_m}, 64'd1);
    chk("flush req_ready low", {63'd0, req_ready_m}, 64'd0);
    @(posedge clock); #1;
    flush = 1'b0;
    #1;
    chk("flush busy", {63'd0, busy_m}, 64'd0);
    chk("flush req_ready", {63'd0, req_ready_m}, 64'd1);
    chk("flush rsp_valid", {63'd0, rsp_valid_m}, 64'd0);
    chk("flush dp_valid", {63'd0, dp_valid_m}, 64'd0);
    // A request alongside flush must not be taken.
    req_rs1 = 32'd9; req_rs2 = 32'd3; req_signed = 1'b0; req_rem = 1'b0;
    flush = 1'b1; req_valid = 1'b1;
    #1;
    chk("flush blocks req_ready", {63'd0, req_ready_m}, 64'd0);
    @(posedge clock); #1;
    flush = 1'b0; req_valid = 1'b0;
    #1;
    chk("flush req not accepted", {63'd0, busy_m}, 64'd0);
    repeat (3) @(posedge clock);
    #1;
    chk("flush no late rsp", {63'd0, rsp_valid_m}, 64'd0);
    send(1'b0, 32'd9, 32'd3, 1'b0, 1'b0);
    wait_rsp(res, lat, runs);
    ack();
    chk("after flush 9/3", {32'd0, res}, 64'd3);

    // Back-pressure in RESP with a queued request.
    send(1'b0, 32'd20, 32'd6, 1'b0, 1'b0);
    wait_rsp(res, lat, runs);
    chk("hold first result", {32'd0, res}, 64'd3);
    r0 = rsp_result_m;
    req_rs1 = 32'd50; req_rs2 = 32'd5; req_signed = 1'b0; req_rem = 1'b0; req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #1;
      chk($sformatf("hold result c%0d", k), {32'd0, rsp_result_m}, {32'd0, r0});
      chk($sformatf("hold rsp_valid c%0d", k), {63'd0, rsp_valid_m}, 64'd1);
      chk($sformatf("hold req_ready c%0d", k), {63'd0, req_ready_m}, 64'd0);
    end
    ack();
    chk("post-ack rsp_valid", {63'd0, rsp_valid_m}, 64'd0);
    chk("post-ack req_ready", {63'd0, req_ready_m}, 64'd1);
    chk("post-ack busy", {63'd0, busy_m}, 64'd0);
    wait_rsp(res, lat, runs);
    ack();
    chk("queued req latency", 64'(lat), 64'd35);
    chk("queued req 50/5", {32'd0, res}, 64'd10);

    // Reset in the middle of RUN.
    send(1'b1, 32'd1000, 32'd7, 1'b0, 1'b1);
    n = 0;
    while (n < 60) begin
      @(posedge clock); #1;
      n++;
      req_valid = 1'b0;
      if (dp_valid_m && run_m && dp_cnt_m == 6'd5) break;
    end
    chk("reset-run counter reached", {58'd0, dp_cnt_m}, 64'd5);
    resetn = 1'b0;
    #1;
    chk("mid reset dp_flush", {63'd0, dp_flush_m}, 64'd1);
    @(posedge clock); #1;
    chk("mid reset req_ready",  {63'd0, req_ready_m}, 64'd1);
    chk("mid reset rsp_valid",  {63'd0, rsp_valid_m}, 64'd0);
    chk("mid reset busy",       {63'd0, busy_m}, 64'd0);
    chk("mid reset dp_valid",   {63'd0, dp_valid_m}, 64'd0);
    chk("mid reset counter",    {58'd0, dp_cnt_m}, 64'd0);
    chk("mid reset acc",        dp_acc_m, 64'd0);
    chk("mid reset arg0",       {32'd0, dp_a0_m}, 64'd0);
    chk("mid reset arg1",       {32'd0, dp_a1_m}, 64'd0);
    chk("mid reset rsp_result", {32'd0, rsp_result_m}, 64'd0);
    resetn = 1'b1;
    @(posedge clock); #1;
    send(1'b1, 32'd1000, 32'd7, 1'b0, 1'b1);
    wait_rsp(res, lat, runs);
    ack();
    chk("after reset 1000%7", {32'd0, res}, 64'd6);

    // Randomised operations against the arithmetic reference.
    for (int i = 0; i < 40; i++) begin
      s  = 1'($urandom_range(0, 1));
      a  = $urandom;
      b  = $urandom;
      sg = 1'($urandom_range(0, 1));
      rm = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: a = 32'($urandom_range(0, 1000));
        3: b = 32'd0 - 32'($urandom_range(1, 15));
        default: ;
      endcase
      send(s, a, b, sg, rm);
      wait_rsp(res, lat, runs);
      ack();
      chk($sformatf("rand%0d %h/%h s%0d r%0d", i, a, b, sg, rm), {32'd0, res},
          {32'd0, ref_div(a, b, sg, rm)});
      chk($sformatf("rand%0d latency", i), 64'(lat),
          (!s && b == 32'd0) ? 64'd2 : 64'd35);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop in case the sequencing above ever wedges.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/xc_malu_divrem_seq.md
Name: xc_malu_divrem_seq

Overview:
Sequencer for the xc_malu_divrem radix-2 restoring divide step datapath.
- Owns the architectural iteration state: 6-bit counter, 64-bit divisor accumulator, 32-bit partial remainder (arg0) and 32-bit quotient (arg1).
- Feeds that state into the step datapath every cycle and registers the next-state outputs.
- Applies signed result correction and RISC-V divide-by-zero semantics.
- Presents a valid/ready request/response interface to the MALU issue logic.

Parameters:
- DIV0_BYPASS, 1: if 1, a zero divisor skips iteration and responds after the FIX cycle. If 0, the zero divisor is iterated and fixed up in FIX.

Ports:
- clock  in  1  clock
- resetn  in  1  synchronous active-low reset
- flush  in  1  abort any operation; synchronous
- req_valid  in  1  request present
- req_ready  out  1  sequencer idle, request accepted when req_valid && req_ready
- req_rs1  in  32  dividend
- req_rs2  in  32  divisor
- req_signed  in  1  signed divide/remainder
- req_rem  in  1  1 = remainder result, 0 = quotient result
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_result  out  32  quotient or remainder
- busy  out  1  state != IDLE
- dp_valid  out  1  to datapath valid
- dp_op_signed  out  1  to datapath op_signed
- dp_flush  out  1  to datapath flush
- dp_rs1  out  32  latched dividend
- dp_rs2  out  32  latched divisor
- dp_counter  out  6  iteration counter
- dp_accumulator  out  64  divisor register
- dp_arg0  out  32  partial remainder register
- dp_arg1  out  32  quotient register
- dp_n_accumulator  in  64  datapath next divisor
- dp_n_arg0  in  32  datapath next remainder
- dp_n_arg1  in  32  datapath next quotient
- dp_finished  in  1  datapath done flag

Behaviour:
- Reset (resetn=0 at posedge):
  - state=IDLE; counter, accumulator, arg0, arg1, latched operands, sign flags and rsp_result all 0.
  - Outputs: rsp_valid=0, req_ready=1, busy=0, dp_valid=0.
  - dp_flush=1 while resetn=0.
- States: IDLE, START, RUN, FIX, RESP.
- IDLE:
  - req_ready=1.
  - On accept, latch rs1, rs2, signed, rem.
  - Latch neg_q = signed && (rs1[31] ^ rs2[31]) and neg_r = signed && rs1[31].
  - Go to START, or to FIX if DIV0_BYPASS && rs2==0.
- START (1 cycle):
  - dp_valid=1; register dp_n_accumulator/dp_n_arg0/dp_n_arg1.
  - counter<=0; go to RUN.
- RUN (exactly 32 cycles, counter 0..31):
  - dp_valid=1; register all dp_n_*.
  - counter<=counter+1.
  - When counter==31 commits, go to FIX.
  - dp_finished must be 1 in the cycle after the last commit. A mismatch is a verification assertion only; the sequencer does not act on it.
- FIX (1 cycle):
  - dp_valid=0, dp_flush=1 (clears datapath run/done).
  - Normal: rsp_result <= rem ? (neg_r ? -arg0 : arg0) : (neg_q ? -arg1 : arg1).
  - Zero divisor: rsp_result <= rem ? rs1 : 32'hFFFFFFFF, regardless of signed.
  - Go to RESP.
- RESP:
  - rsp_valid=1, rsp_result stable.
  - On rsp_ready, go to IDLE, clear rsp_valid.
  - A new request can be accepted the cycle after the handshake; no same-cycle overlap.
- Latency:
  - Accept at edge T: rsp_valid visible after edge T+35 (START 1 + RUN 32 + FIX 1 + RESP entry).
  - Zero-divisor bypass: rsp_valid after edge T+2.
- Flush:
  - At any posedge, flush=1 forces IDLE and rsp_valid=0. A pending response is discarded.
  - dp_flush = flush || !resetn || state==FIX (combinational).
  - A request presented in the same cycle as flush is not accepted; req_ready=0 while flush=1.
- Overflow case (signed, -2^31 / -1): no special path. The magnitude path yields quotient 0x80000000 and remainder 0, matching RISC-V.
- Arithmetic:
  - All negations are 32-bit two's complement, wrap-around permitted.
  - The counter never exceeds 32 and is held outside RUN.
- Protocol rules:
  - req_* are ignored unless accepted.
  - rsp_result must not change while rsp_valid=1.

Test Plan:
- Unsigned 100/7, rem=0 then rem=1 -> rsp_result 14 then 2; rsp_valid exactly 35 cycles after accept; 32 dp_valid RUN cycles observed.
- Signed -100/7 -> quotient 0xFFFFFFF2 (-14), remainder 0xFFFFFFFE (-2); signed 100/-7 -> quotient -14, remainder 2.
- Divide by zero, signed, rs1=0x80000005, DIV0_BYPASS=1 -> quotient 0xFFFFFFFF, remainder 0x80000005, rsp_valid 2 cycles after accept; repeat with DIV0_BYPASS=0 -> same values after 35 cycles.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
- Flush at RUN counter==10 -> next cycle state IDLE, req_ready=1, dp_flush pulsed, no rsp_valid; subsequent 9/3 -> 3 correct.
- Hold rsp_ready=0 for 5 cycles in RESP with req_valid=1 -> rsp_result stable, req_ready=0; after handshake, next request accepted one cycle later; resetn=0 mid-RUN -> all outputs at reset values next cycle.
